lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer for the RV32I core. It accepts one LTYPE/STYPE operation from decode, checks alignment and funct3 legality, and drives a request/grant/response data-memory port. It generates byte enables, replicates write data across lanes, and sign- or zero-extends load data. It stalls the core until the access completes or faults.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+RESP before a bus-timeout fault (1..65535)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse: decoded load/store valid this cycle
is_store_i  in  1  1 = store (STYPE), 0 = load (LTYPE)
funct3_i  in  3  instr[14:12]
addr_i  in  32  effective address (rs1 + imm)
wdata_i  in  32  rs2 value for stores
stall_o  out  1  hold PC/pipeline
done_o  out  1  one-cycle pulse: access complete, rdata_o valid for loads
rdata_o  out  32  extended load result
fault_o  out  1  one-cycle pulse: access aborted
fault_cause_o  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; valid with fault_o
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address, {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated write data
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  response/ack valid (loads and stores)
mem_rdata_i  in  32  read word

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE, counter 0, every registered output 0. That covers stall_o, done_o, rdata_o, fault_o, fault_cause_o and all mem_* outputs. Reset mid-access drops mem_req_o immediately and discards the access.
- Funct3 encoding, loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010. Any other value is illegal.
- States: IDLE, REQ, RESP, DONE, ERR.
- IDLE: on start_i, latch is_store, funct3, addr[1:0] and wdata.
  - Illegal funct3 -> ERR, cause 10 (illegal takes priority over misalignment).
  - Otherwise misaligned (half with addr[0]=1, word with addr[1:0]≠0) -> ERR, cause 01. No memory request is issued.
  - Otherwise -> REQ.
- REQ: mem_req_o=1; mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o are registered and held stable until grant. On mem_gnt_i -> RESP and mem_req_o deasserts next cycle.
- RESP: wait for mem_rvalid_i. When it arrives, capture the extended load data into rdata_o (stores leave rdata_o unchanged) -> DONE. An rvalid arriving in any other state is ignored.
- DONE: done_o=1 for one cycle -> IDLE.
- ERR: fault_o=1 for one cycle with fault_cause_o -> IDLE. fault_cause_o holds its last value afterwards.
- stall_o = start_i | (state∈{REQ,RESP}). It is combinational on start_i. It is low in DONE and ERR, so the core commits and advances that cycle.
- start_i while not IDLE is ignored.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/RESP.
  - When count == TIMEOUT_CYCLES-1 and the exit condition is absent -> ERR, cause 11, mem_req_o dropped.
  - Exit condition and timeout in the same cycle: the exit wins.
- Byte enables (a = addr[1:0]):
  - byte: 4'b0001<<a
  - half: 4'b0011<<{a[1],1'b0}
  - word: 4'b1111
- Write data lanes:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extraction: shift = mem_rdata_i >> (8*a).
  - LB: sign-extend shift[7:0]
  - LBU: zero-extend shift[7:0]
  - LH: sign-extend shift[15:0]
  - LHU: zero-extend shift[15:0]
  - LW: full word
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first RESP cycle:
  - start_i at cycle 0
  - REQ at cycle 1
  - RESP at cycle 2
  - done_o at cycle 3
- Faults appear one cycle after start_i.

Test Plan:
- LW addr 0x100, gnt immediately, rvalid 1 cycle later with rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, we=0; done_o at cycle 3; rdata_o=0xDEADBEEF; stall_o high cycles 0-2.
- LB addr 0x203, rdata 0x80112233 -> be=1000, rdata_o=0xFFFFFF80. Repeat with LBU -> 0x00000080. LHU addr 0x202 -> 0x00008011.
- SH addr 0x302, wdata 0x1234ABCD -> we=1, addr 0x300, be=1100, wdata 0xABCDABCD; done_o after rvalid; rdata_o unchanged.
- Misaligned and illegal cases:
  - LW addr 0x101 -> no mem_req_o; fault_o at cycle 1 with cause 01.
  - Load funct3 011 -> cause 10.
  - Store funct3 011 with addr 0x1 -> cause 10 (illegal wins).
- TIMEOUT_CYCLES=8, gnt never asserted -> mem_req_o high exactly 8 cycles; fault_o cause 11; then IDLE. A new start_i after that completes normally.
- Start an access, stall gnt 3 cycles, pulse start_i twice mid-access, then assert rst_n low in RESP -> the extra start_i pulses are ignored; on reset all outputs go 0 asynchronously; no done_o is issued; the next access after reset behaves normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer driving a req/gnt/rvalid data-memory port.
// Checks funct3 legality and alignment, builds byte enables and lane data, extends loads.
`default_nettype none

module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] RESP = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b11;
    localparam logic [15:0] CNT_LAST       = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state, state_next;
    logic [15:0] count;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        legal, misaligned, timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_shift, load_ext;

    // Decode of the incoming operation; only consumed in IDLE on start_i.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !is_store_i;
            default:                legal = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr_i[1:0];
                wdata_calc = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_calc    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_calc = {2{wdata_i[15:0]}};
            end
            default: misaligned = (addr_i[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        load_shift = mem_rdata_i >> {offset, 3'b000};
        case (funct3)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b100:  load_ext = {24'd0, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b101:  load_ext = {16'd0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    assign timeout_hit = (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A grant or response in the timeout cycle still completes the access.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_i) state_next = (!legal || misaligned) ? ERR : REQ;
            REQ:  if (mem_gnt_i) state_next = RESP;
                  else if (timeout_hit) state_next = ERR;
            RESP: if (mem_rvalid_i) state_next = DONE;
                  else if (timeout_hit) state_next = ERR;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = (state == REQ);
        done_o    = (state == DONE);
        fault_o   = (state == ERR);
        stall_o   = start_i | (state == REQ) | (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            funct3        <= '0;
            offset        <= '0;
            rdata_o       <= '0;
            fault_cause_o <= '0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
        end else begin
            if (state == IDLE) begin
                count <= '0;
                if (start_i) begin
                    funct3      <= funct3_i;
                    offset      <= addr_i[1:0];
                    mem_we_o    <= is_store_i;
                    mem_addr_o  <= {addr_i[31:2], 2'b00};
                    mem_be_o    <= be_calc;
                    mem_wdata_o <= wdata_calc;
                    if (!legal)          fault_cause_o <= CAUSE_ILLEGAL;
                    else if (misaligned) fault_cause_o <= CAUSE_MISALIGN;
                end
            end else if (state == REQ || state == RESP) begin
                count <= count + 16'd1;
                if (state_next == ERR) fault_cause_o <= CAUSE_TIMEOUT;
            end
            if (state == RESP && mem_rvalid_i && !mem_we_o) rdata_o <= load_ext;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl; stimulus pushes expectations, monitor pops on handshakes.
`default_nettype none

module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, fault_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_cause_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_store_i(is_store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .fault_o(fault_o), .fault_cause_o(fault_cause_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic fault; logic [1:0] cause; logic [31:0] rdata; int lat; } rsp_t;

    req_t reqq[$];
    rsp_t rspq[$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, t_start = 0, req_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic void push_req(logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.be = be; r.wdata = wd;
        reqq.push_back(r);
    endfunction

    function automatic void push_rsp(logic f, logic [1:0] c, logic [31:0] rd, int lat);
        rsp_t r;
        r.fault = f; r.cause = c; r.rdata = rd; r.lat = lat;
        rspq.push_back(r);
    endfunction

    // Monitor: compares the request at grant and the result at done/fault.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_o) req_cycles++;
            if (mem_req_o && mem_gnt_i) begin
                if (reqq.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                else begin
                    req_t e;
                    e = reqq.pop_front();
                    check("req_addr", mem_addr_o, e.addr);
                    check("req_we", {31'd0, mem_we_o}, {31'd0, e.we});
                    check("req_be", {28'd0, mem_be_o}, {28'd0, e.be});
                    check("req_wdata", mem_wdata_o, e.wdata);
                end
            end
            if (done_o || fault_o) begin
                if (rspq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    rsp_t e;
                    e = rspq.pop_front();
                    check("rsp_kind", {30'd0, done_o, fault_o}, e.fault ? 32'd1 : 32'd2);
                    if (e.fault) check("fault_cause", {30'd0, fault_cause_o}, {30'd0, e.cause});
                    else         check("rdata", rdata_o, e.rdata);
                    if (e.lat >= 0) check("latency", cyc - t_start, e.lat);
                end
            end
        end
    end

    task automatic drive_start(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        start_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        t_start = cyc;
    endtask

    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rdat);
        drive_start(st, f3, a, wd);
        @(negedge clk); check("stall_start", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1; start_i = 1'b0;
        for (int i = 0; i < gd; i++) begin
            @(negedge clk); check("stall_req", {31'd0, stall_o}, 32'd1);
            @(posedge clk); #1;
        end
        mem_gnt_i = 1'b1;
        @(negedge clk); check("stall_gnt", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1; mem_gnt_i = 1'b0;
        for (int i = 0; i < rd; i++) begin
            @(negedge clk); check("stall_resp", {31'd0, stall_o}, 32'd1);
            @(posedge clk); #1;
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = rdat;
        @(negedge clk); check("stall_rvalid", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1; mem_rvalid_i = 1'b0;
        @(negedge clk); check("stall_done", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input int wait_cycles);
        drive_start(st, f3, a, 32'd0);
        @(posedge clk); #1; start_i = 1'b0;
        repeat (wait_cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start_i = 1'b0; is_store_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_fault", {31'd0, fault_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_cause", {30'd0, fault_cause_o}, 32'd0);
        rst_n = 1'b1;

        push_req(32'h100, 1'b0, 4'b1111, 32'd0); push_rsp(1'b0, 2'b00, 32'hDEADBEEF, 3);
        access(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF);
        push_req(32'h200, 1'b0, 4'b1000, 32'd0); push_rsp(1'b0, 2'b00, 32'hFFFFFF80, 3);
        access(1'b0, 3'b000, 32'h203, 32'd0, 0, 0, 32'h80112233);
        push_req(32'h200, 1'b0, 4'b1000, 32'd0); push_rsp(1'b0, 2'b00, 32'h00000080, 3);
        access(1'b0, 3'b100, 32'h203, 32'd0, 0, 0, 32'h80112233);
        push_req(32'h200, 1'b0, 4'b1100, 32'd0); push_rsp(1'b0, 2'b00, 32'h00008011, 3);
        access(1'b0, 3'b101, 32'h202, 32'd0, 0, 0, 32'h80112233);
        push_req(32'h200, 1'b0, 4'b1100, 32'd0); push_rsp(1'b0, 2'b00, 32'hFFFF8011, -1);
        access(1'b0, 3'b001, 32'h202, 32'd0, 2, 1, 32'h80112233);
        push_req(32'h300, 1'b1, 4'b1100, 32'hABCDABCD); push_rsp(1'b0, 2'b00, 32'hFFFF8011, 3);
        access(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 0, 0, 32'h55555555);
        push_req(32'h000, 1'b1, 4'b0010, 32'hA5A5A5A5); push_rsp(1'b0, 2'b00, 32'hFFFF8011, 3);
        access(1'b1, 3'b000, 32'h001, 32'h000000A5, 0, 0, 32'h55555555);

        req_cycles = 0;
        push_rsp(1'b1, 2'b01, 32'd0, 1); issue(1'b0, 3'b010, 32'h101, 3);
        push_rsp(1'b1, 2'b10, 32'd0, 1); issue(1'b0, 3'b011, 32'h000, 3);
        push_rsp(1'b1, 2'b10, 32'd0, 1); issue(1'b1, 3'b011, 32'h001, 3);
        check("fault_no_req", req_cycles, 32'd0);

        req_cycles = 0;
        push_rsp(1'b1, 2'b11, 32'd0, 9); issue(1'b0, 3'b010, 32'h600, 14);
        check("timeout_req_cycles", req_cycles, 32'd8);
        check("cause_held", {30'd0, fault_cause_o}, 32'd3);
        push_req(32'h604, 1'b0, 4'b1111, 32'd0); push_rsp(1'b0, 2'b00, 32'h13579BDF, 3);
        access(1'b0, 3'b010, 32'h604, 32'd0, 0, 0, 32'h13579BDF);

        // Extra start pulses mid-access, then reset while in RESP.
        push_req(32'h400, 1'b0, 4'b1111, 32'd0);
        drive_start(1'b0, 3'b010, 32'h400, 32'd0);
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1; start_i = 1'b1; addr_i = 32'h500; funct3_i = 3'b000;
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1; start_i = 1'b1; mem_gnt_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk); check("stall_in_resp", {31'd0, stall_o}, 32'd1);
        #1; rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req_o}, 32'd0);
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_fault", {31'd0, fault_o}, 32'd0);
        check("arst_rdata", rdata_o, 32'd0);
        check("arst_addr", mem_addr_o, 32'd0);
        check("arst_cause", {30'd0, fault_cause_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        push_req(32'h700, 1'b0, 4'b0010, 32'd0); push_rsp(1'b0, 2'b00, 32'hFFFFFFAB, 3);
        access(1'b0, 3'b000, 32'h701, 32'd0, 0, 0, 32'h0000AB00);
        repeat (3) @(posedge clk);

        check("rsp_queue_empty", rspq.size(), 32'd0);
        check("req_queue_empty", reqq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
